// File: rtl/instr_encoder.sv
// instr_encoder
// Encodes RISC-V I/S/B-type instruction words from separate fields and a
// signed immediate, then writes them sequentially into instruction memory
// through a write port that honours backpressure.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   clr            synchronous restart (address/count back to 0)
//   in_valid/in_ready, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm
//                  encode request (fmt: 0 I-load, 1 I-ALU, 2 S, 3 B)
//   mem_we/mem_ready, mem_addr, mem_wdata
//                  memory write port, request held until accepted
//   count, full    words written (saturating at 2^ADDR_W) and full flag
//   err_valid, err_code
//                  one-cycle error pulse (01 range, 10 misaligned branch)
//
// Optional feature: define INSTR_ENC_CHECK_EN to enable immediate range and
// branch-alignment checks. Without it immediates are truncated silently and
// the error outputs stay 0.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_valid_q, err_valid_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                full_w;
  logic                accept;
  logic [31:0]         enc;
  logic                chk_err;
  logic [1:0]          chk_code;

  assign full_w   = (count_q == CAP);
  assign in_ready = (state_q == IDLE) && !full_w && !clr;
  assign accept   = in_valid && in_ready;

  always_comb begin
    enc = '0;
    case (in_fmt)
      2'd0:    enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      2'd1:    enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      2'd2:    enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0],
                      7'b0100011};
      default: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], 7'b1100011};
    endcase
  end

`ifdef INSTR_ENC_CHECK_EN
  logic i_oor, b_oor, b_mis;

  // An immediate fits when all bits above its sign bit replicate it.
  assign i_oor = !((&in_imm[31:11]) || !(|in_imm[31:11]));
  assign b_oor = !((&in_imm[31:12]) || !(|in_imm[31:12]));
  assign b_mis = in_imm[0];

  always_comb begin
    chk_err  = 1'b0;
    chk_code = '0;
    if (in_fmt == 2'd3) begin
      if (b_mis) begin
        chk_err  = 1'b1;
        chk_code = 2'b10;
      end else if (b_oor) begin
        chk_err  = 1'b1;
        chk_code = 2'b01;
      end
    end else if (i_oor) begin
      chk_err  = 1'b1;
      chk_code = 2'b01;
    end
  end
`else
  logic unused_imm;

  assign chk_err    = 1'b0;
  assign chk_code   = '0;
  assign unused_imm = ^{in_imm[31:13], in_imm[0]};
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    if (clr) begin
      // Abandons any pending write without a handshake.
      state_d = IDLE;
      addr_d  = '0;
      count_d = '0;
      we_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (chk_err) begin
              err_valid_d = 1'b1;
              err_code_d  = chk_code;
            end else begin
              wdata_d = enc;
              we_d    = 1'b1;
              state_d = HOLD;
            end
          end
        end
        default: begin
          if (mem_ready) begin
            we_d    = 1'b0;
            addr_d  = addr_q + ADDR_W'(1);
            if (count_q != CAP) count_d = count_q + (ADDR_W + 1)'(1);
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign full      = full_w;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule
